// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: loads a cipher key, then emits round keys 0..10
// one per valid/ready handshake, computing the next key in a single cycle.

module aes_sbox (
    input  logic [7:0] i_addr,
    output logic [7:0] o_data
);
    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = 11'd2047 - {i_addr, 3'b000};
    assign o_data = SBOX_TABLE[w_base -: 8];
endmodule

module aes_key_expand #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] round_key,
    output logic [3:0]       round_idx,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic             busy,
    output logic             done
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [KEY_W-1:0] r_round_key;
    logic [KEY_W-1:0] w_round_key_nxt;
    logic [3:0]       r_round_idx;
    logic [3:0]       w_round_idx_nxt;
    logic             r_rk_valid;
    logic             w_rk_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [7:0]       r_rcon;
    logic [7:0]       w_rcon_nxt;

    logic             w_hs;
    logic             w_last;
    logic [31:0]      w_w0;
    logic [31:0]      w_w1;
    logic [31:0]      w_w2;
    logic [31:0]      w_w3;
    logic [31:0]      w_rot;
    logic [31:0]      w_sub;
    logic [31:0]      w_t;
    logic [31:0]      w_n0;
    logic [31:0]      w_n1;
    logic [31:0]      w_n2;
    logic [31:0]      w_n3;
    logic [KEY_W-1:0] w_next_key;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign w_hs   = r_rk_valid & rk_ready;
    assign w_last = (r_round_idx == 4'(NUM_ROUNDS));

    assign w_w0  = r_round_key[127:96];
    assign w_w1  = r_round_key[95:64];
    assign w_w2  = r_round_key[63:32];
    assign w_w3  = r_round_key[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_addr (w_rot[8*g +: 8]),
            .o_data (w_sub[8*g +: 8])
        );
    end

    assign w_t        = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0       = w_w0 ^ w_t;
    assign w_n1       = w_w1 ^ w_n0;
    assign w_n2       = w_w2 ^ w_n1;
    assign w_n3       = w_w3 ^ w_n2;
    assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

    // Without a handshake every output holds, so the consumer never misses a key.
    always_comb begin
        w_state_nxt     = r_state;
        w_round_key_nxt = r_round_key;
        w_round_idx_nxt = r_round_idx;
        w_rk_valid_nxt  = r_rk_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_rcon_nxt      = r_rcon;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt     = ST_RUN;
                    w_round_key_nxt = key_in;
                    w_round_idx_nxt = 4'd0;
                    w_rk_valid_nxt  = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_rcon_nxt      = 8'h01;
                end
            end
            ST_RUN: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_state_nxt    = ST_IDLE;
                        w_rk_valid_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_done_nxt     = 1'b1;
                    end else begin
                        w_round_key_nxt = w_next_key;
                        w_round_idx_nxt = r_round_idx + 4'd1;
                        w_rcon_nxt      = xtime(r_rcon);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_round_key <= '0;
            r_round_idx <= 4'd0;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rcon      <= 8'h01;
        end else begin
            r_state     <= w_state_nxt;
            r_round_key <= w_round_key_nxt;
            r_round_idx <= w_round_idx_nxt;
            r_rk_valid  <= w_rk_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_rcon      <= w_rcon_nxt;
        end
    end

    assign round_key = r_round_key;
    assign round_idx = r_round_idx;
    assign rk_valid  = r_rk_valid;
    assign busy      = r_busy;
    assign done      = r_done;
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: stimulus queues expected round keys,
// a negedge monitor pops and compares on every accepted handshake.

module tb_aes_key_expand;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_RK [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    aes_key_expand #(
        .KEY_W      (128),
        .NUM_ROUNDS (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .round_key (round_key),
        .round_idx (round_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input bit zero_key);
        for (int i = 0; i < 11; i++) begin
            sb_q.push_back('{idx: 4'(i), key: zero_key ? ZERO_RK[i] : FIPS_RK[i]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idx(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (rk_valid && round_idx == target) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic run_expand(input logic [127:0] k, input string tag);
        int nvalid;
        bit seen;
        nvalid = 0;
        seen   = 1'b0;
        start  = 1'b1;
        key_in = k;
        tick();
        start  = 1'b0;
        key_in = ~k;
        check({tag, "_busy"}, busy, 1);
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (rk_valid) nvalid++;
            tick();
        end
        check({tag, "_valid_cycles"}, nvalid, 11);
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_valid_at_done"}, rk_valid, 0);
        tick();
        check({tag, "_done_pulse_len"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    // Compare every accepted round key against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && rk_valid && rk_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got idx %0d with empty queue expected no handshake", round_idx);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_idx", round_idx, mon_e.idx);
                check("sb_key", round_key, mon_e.key);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        repeat (3) tick();
        check("rst_key", round_key, 0);
        check("rst_idx", round_idx, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // FIPS-197 key with the consumer always ready
        rk_ready = 1'b1;
        push_seq(1'b0);
        run_expand(FIPS_KEY, "fips");
        check("fips_retain_key", round_key, FIPS_RK[10]);
        check("fips_retain_idx", round_idx, 10);

        // Backpressure at round 3
        push_seq(1'b0);
        start  = 1'b1;
        key_in = FIPS_KEY;
        tick();
        start = 1'b0;
        wait_idx(4'd3, ok);
        check("bp_reach3", ok, 1);
        rk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_hold_key", round_key, FIPS_RK[3]);
            check("bp_hold_idx", round_idx, 3);
            check("bp_hold_valid", rk_valid, 1);
        end
        rk_ready = 1'b1;
        wait_done(ok);
        check("bp_done", ok, 1);
        check("bp_final_key", round_key, FIPS_RK[10]);
        tick();

        // start during RUN with a different key is ignored
        push_seq(1'b0);
        start  = 1'b1;
        key_in = FIPS_KEY;
        tick();
        start = 1'b0;
        wait_idx(4'd4, ok);
        check("ign_reach4", ok, 1);
        start  = 1'b1;
        key_in = 128'hffeeddccbbaa99887766554433221100;
        tick();
        start = 1'b0;
        check("ign_busy", busy, 1);
        wait_done(ok);
        check("ign_done", ok, 1);
        tick();

        // Reset mid-run at round 6, with start also high
        push_seq(1'b0);
        start  = 1'b1;
        key_in = FIPS_KEY;
        tick();
        start = 1'b0;
        wait_idx(4'd6, ok);
        check("rst6_reach6", ok, 1);
        rst    = 1'b1;
        start  = 1'b1;
        key_in = FIPS_KEY;
        tick();
        sb_q.delete();
        check("rst6_valid", rk_valid, 0);
        check("rst6_busy", busy, 0);
        check("rst6_key", round_key, 0);
        check("rst6_idx", round_idx, 0);
        check("rst6_done", done, 0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        check("rst6_still_idle", rk_valid, 0);

        // All-zero key after the reset (rcon must restart at 01)
        push_seq(1'b1);
        run_expand(128'h0, "zero");
        check("zero_retain_key", round_key, ZERO_RK[10]);

        // start held high across done: second expansion starts right after done
        push_seq(1'b0);
        push_seq(1'b0);
        start  = 1'b1;
        key_in = FIPS_KEY;
        wait_done(ok);
        check("b2b_done1", ok, 1);
        tick();
        check("b2b_valid", rk_valid, 1);
        check("b2b_idx0", round_idx, 0);
        check("b2b_key0", round_key, FIPS_RK[0]);
        check("b2b_done_low", done, 0);
        start = 1'b0;
        wait_done(ok);
        check("b2b_done2", ok, 1);
        tick();

        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
